// File: rtl/uart_frame_tx.sv
// uart_frame_tx: UART transmitter with a built-in baud timer and a valid/ready
// input handshake. Sends start, FRAME_DATA_LENGTH data bits, an optional
// parity bit and one or two stop bits, LSB-first or MSB-first.
module uart_frame_tx #(
  parameter int NATIVE_CLK_FREQUENCY = 50000000,
  parameter int BAUDRATE             = 9600,
  parameter int FRAME_DATA_LENGTH    = 8,
  parameter int PARITY_MODE          = 0,
  parameter int STOP_BITS            = 1,
  parameter int ENABLE_BIG_ENDIAN    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FRAME_DATA_LENGTH-1:0] data,
  input  logic                         valid,
  output logic                         ready,
  output logic                         tx,
  output logic                         busy
);

  localparam int BIT_PERIOD = NATIVE_CLK_FREQUENCY / BAUDRATE;
  localparam int CNT_W      = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BIT_PERIOD - 1);
  localparam logic [3:0]       DATA_LAST  = 4'(FRAME_DATA_LENGTH - 1);
  localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
  // Mode 3 (and anything else outside 1/2) means no parity bit at all
  localparam bit               HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parameter sanity checks, caught at elaboration time
  if (BIT_PERIOD < 2) begin : g_bad_bit_period
    $error("uart_frame_tx: BIT_PERIOD must be at least 2");
  end
  if (FRAME_DATA_LENGTH < 5 || FRAME_DATA_LENGTH > 9) begin : g_bad_data_length
    $error("uart_frame_tx: FRAME_DATA_LENGTH must be within 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_frame_tx: STOP_BITS must be 1 or 2");
  end

  logic [2:0]                   state;
  logic [CNT_W-1:0]             baud_cnt;
  logic [3:0]                   bit_idx;
  logic [FRAME_DATA_LENGTH-1:0] shift_reg;
  logic                         parity_bit;
  logic [FRAME_DATA_LENGTH-1:0] load_word;
  logic                         parity_next;
  logic                         accept;
  logic                         bit_end;

  assign accept  = valid && ready;
  assign bit_end = (baud_cnt == CNT_LAST);
  assign busy    = ~ready;

  // Parity of the word being accepted; odd mode is the inverted XOR
  assign parity_next = (PARITY_MODE == 2) ? ~(^data) : (^data);

  // For MSB-first frames the word is reversed on load so the shifter always emits bit 0
  always_comb begin
    load_word = data;
    if (ENABLE_BIG_ENDIAN != 0) begin
      for (int i = 0; i < FRAME_DATA_LENGTH; i++) begin
        load_word[i] = data[FRAME_DATA_LENGTH-1-i];
      end
    end
  end

  // Frame sequencer: baud counter restarts at every bit boundary, tx and ready are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      ready      <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shift_reg  <= load_word;
            parity_bit <= parity_next;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            tx         <= 1'b0;
            ready      <= 1'b0;
            state      <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (HAS_PARITY) begin
                tx    <= parity_bit;
                state <= ST_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              bit_idx   <= bit_idx + 4'd1;
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              ready   <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= ST_IDLE;
          tx       <= 1'b1;
          ready    <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: scoreboard bench for uart_frame_tx. Five instances cover
// 8N1 LSB-first, MSB-first, even parity, odd parity and 7-bit/2-stop frames,
// all with a 16-cycle bit period. Expected line levels are written by hand.
module tb_uart_frame_tx;

  localparam int BP = 16;

  typedef struct {
    logic [15:0] levels;
    int          nbits;
    int          gap;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] data_bus;
  logic [4:0] valid_v;
  logic [4:0] ready_v;
  logic [4:0] tx_v;
  logic [4:0] busy_v;

  int   compares;
  int   fails;
  int   sel;
  int   cyc;
  bit   mon_active;
  exp_t sb_q[$];

  uart_frame_tx #(.NATIVE_CLK_FREQUENCY(160), .BAUDRATE(10)) u_lsb (
    .clk(clk), .rst(rst), .data(data_bus), .valid(valid_v[0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));

  uart_frame_tx #(.NATIVE_CLK_FREQUENCY(160), .BAUDRATE(10), .ENABLE_BIG_ENDIAN(1)) u_msb (
    .clk(clk), .rst(rst), .data(data_bus), .valid(valid_v[1]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));

  uart_frame_tx #(.NATIVE_CLK_FREQUENCY(160), .BAUDRATE(10), .PARITY_MODE(1)) u_even (
    .clk(clk), .rst(rst), .data(data_bus), .valid(valid_v[2]),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));

  uart_frame_tx #(.NATIVE_CLK_FREQUENCY(160), .BAUDRATE(10), .PARITY_MODE(2)) u_odd (
    .clk(clk), .rst(rst), .data(data_bus), .valid(valid_v[3]),
    .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));

  uart_frame_tx #(.NATIVE_CLK_FREQUENCY(160), .BAUDRATE(10), .FRAME_DATA_LENGTH(7),
                  .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .data(data_bus[6:0]), .valid(valid_v[4]),
    .ready(ready_v[4]), .tx(tx_v[4]), .busy(busy_v[4]));

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure the gap between consecutive frames
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compares++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 'h%0h, want 'h%0h", name, actual, expected);
    end
  endtask

  task automatic failBound(input string name, input int limit);
    compares++;
    fails++;
    $display("[TB] FAIL %s: no response within %0d cycles, want a response", name, limit);
  endtask

  // Push the expected frame, then offer the word until the selected instance accepts it
  task automatic applyStimulus(input int s, input logic [7:0] word, input logic [15:0] lv,
                               input int nb, input int gap, input bit push);
    int n;
    @(negedge clk);
    sel = s;
    if (push) sb_q.push_back('{levels: lv, nbits: nb, gap: gap});
    data_bus   = word;
    valid_v[s] = 1'b1;
    n = 0;
    while (ready_v[s] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) failBound($sformatf("accept_%0h", word), 500);
    @(negedge clk);
    valid_v[s] = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || mon_active) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1500) begin
      failBound({name, "_drain"}, 1500);
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic waitReady(input string name, input logic level);
    int n;
    n = 0;
    while (ready_v[0] !== level && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) failBound(name, 400);
  endtask

  // Monitor: on each start bit pop the next expected frame and check every bit cycle
  initial begin : monitor
    exp_t        it;
    int          frame_no;
    int          start_cyc;
    int          last_end;
    int          bad;
    logic        lvl;
    frame_no   = 0;
    last_end   = -1000;
    mon_active = 1'b0;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0 && tx_v[sel] === 1'b0) begin
        it         = sb_q.pop_front();
        mon_active = 1'b1;
        start_cyc  = cyc;
        if (it.gap >= 0)
          checkOutput($sformatf("f%0d.idle_gap", frame_no),
                      16'(start_cyc - last_end - 1), 16'(it.gap));
        for (int b = 0; b < it.nbits; b++) begin
          lvl = it.levels[it.nbits-1-b];
          bad = 0;
          for (int c = 0; c < BP; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (tx_v[sel] !== lvl || ready_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) bad++;
          end
          checkOutput($sformatf("f%0d.bit%0d(level %b) off-cycles", frame_no, b, lvl),
                      16'(bad), 16'd0);
        end
        last_end = cyc;
        @(negedge clk);
        checkOutput($sformatf("f%0d.after_stop{tx,ready,busy}", frame_no),
                    16'({tx_v[sel], ready_v[sel], busy_v[sel]}), 16'b110);
        frame_no++;
        mon_active = 1'b0;
      end
    end
  end

  // Global guard so a stuck DUT can never hang the run
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: run still active after 20000 cycles, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin : stimulus
    int bad;
    compares = 0;
    fails    = 0;
    sel      = 0;
    rst      = 1'b1;
    valid_v  = '0;
    data_bus = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx_all", 16'(tx_v), 16'h1F);
    checkOutput("reset_ready_all", 16'(ready_v), 16'h1F);
    checkOutput("reset_busy_all", 16'(busy_v), 16'h00);
    rst = 1'b0;

    $display("[TB] 8N1 LSB-first");
    applyStimulus(0, 8'hA5, 16'(10'b0101001011), 10, -1, 1'b1);
    waitDrain("lsb_a5");
    applyStimulus(0, 8'h3C, 16'(10'b0001111001), 10, -1, 1'b1);
    waitDrain("lsb_3c");

    $display("[TB] 8N1 MSB-first");
    applyStimulus(1, 8'hA5, 16'(10'b0101001011), 10, -1, 1'b1);
    waitDrain("msb_a5");
    applyStimulus(1, 8'hC2, 16'(10'b0110000101), 10, -1, 1'b1);
    waitDrain("msb_c2");
    applyStimulus(1, 8'h01, 16'(10'b0000000011), 10, -1, 1'b1);
    waitDrain("msb_01");

    $display("[TB] even and odd parity");
    applyStimulus(2, 8'hA5, 16'(11'b01010010101), 11, -1, 1'b1);
    waitDrain("even_a5");
    applyStimulus(2, 8'h07, 16'(11'b01110000011), 11, -1, 1'b1);
    waitDrain("even_07");
    applyStimulus(3, 8'hA5, 16'(11'b01010010111), 11, -1, 1'b1);
    waitDrain("odd_a5");
    applyStimulus(3, 8'h07, 16'(11'b01110000001), 11, -1, 1'b1);
    waitDrain("odd_07");

    $display("[TB] 7 data bits, 2 stop bits");
    applyStimulus(4, 8'h55, 16'(10'b0101010111), 10, -1, 1'b1);
    waitDrain("7n2_55");
    applyStimulus(4, 8'h0F, 16'(10'b0111100011), 10, -1, 1'b1);
    waitDrain("7n2_0f");

    $display("[TB] back-to-back with valid held high");
    @(negedge clk);
    sel = 0;
    sb_q.push_back('{levels: 16'(10'b0000000001), nbits: 10, gap: -1});
    sb_q.push_back('{levels: 16'(10'b0111111111), nbits: 10, gap: 1});
    data_bus   = 8'h00;
    valid_v[0] = 1'b1;
    waitReady("b2b_first_accept", 1'b0);
    data_bus = 8'hFF;
    waitReady("b2b_ready_return", 1'b1);
    waitReady("b2b_second_accept", 1'b0);
    valid_v[0] = 1'b0;
    repeat (40) @(negedge clk);
    data_bus   = 8'h3C;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    repeat (50) @(negedge clk);
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    waitDrain("b2b");
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    checkOutput("dropped_valid_no_extra_frame", 16'(bad), 16'd0);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(0, 8'hA5, 16'h0000, 10, -1, 1'b0);
    repeat (3 * BP) @(negedge clk);
    checkOutput("mid_frame_busy", 16'(busy_v[0]), 16'd1);
    rst        = 1'b1;
    valid_v[0] = 1'b1;
    data_bus   = 8'h99;
    @(negedge clk);
    checkOutput("abort_tx", 16'(tx_v[0]), 16'd1);
    checkOutput("abort_ready", 16'(ready_v[0]), 16'd1);
    checkOutput("abort_busy", 16'(busy_v[0]), 16'd0);
    rst        = 1'b0;
    valid_v[0] = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) bad++;
    end
    checkOutput("abort_stays_idle", 16'(bad), 16'd0);
    applyStimulus(0, 8'h3C, 16'(10'b0001111001), 10, -1, 1'b1);
    waitDrain("after_abort_3c");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
